npu_host_ctrl: RTL and testbench
================================

Name: npu_host_ctrl

Overview:
- Host-side sequencer that drives the NPU's shared 32-bit bidirectional bus, playing the initiator end of its we/oe/ready protocol.
- Pulls a job word stream (6-word config header, then weights+biases, then the input vector) from a source FIFO and writes it onto the bus with npu_we.
- Waits for npu_ready, then reads the output-layer results with npu_oe and pushes them to a result stream.
- Sits between the system DMA/buffer and one NPU instance.

Parameters:
TIMEOUT_CYCLES, 65535, maximum cycles in WAIT_RDY before aborting with err
CNT_W, 12, width of the payload word counter (maximum payload is 3 x 32 x 33 + 32 = 3200 words)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a job; ignored unless in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the last result is accepted
err  output  1  sticky error flag; cleared by the next accepted start
src_data  input  32  job word stream
src_valid  input  1  src_data valid
src_ready  output  1  block accepts the src word this cycle
npu_data  inout  32  NPU shared bus; driven only while npu_we=1, otherwise Z
npu_we  output  1  write strobe; the NPU samples npu_data on each clk edge where npu_we=1
npu_oe  output  1  read enable; the NPU drives npu_data combinationally while npu_oe=1
npu_ready  input  1  NPU results available
res_data  output  32  result word
res_valid  output  1  res_data valid
res_ready  input  1  result consumer accepts the word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err, src_ready, npu_we, npu_oe and res_valid all 0; res_data=0; bus released immediately.
- States: IDLE, HDR, CALC, LOAD, WAIT_RDY, READ, FIN.
- IDLE: on start, go to HDR, clear err, set word counter to 0.
- HDR:
  - src_ready=1; each accepted word is registered to the bus with npu_we=1 on the next cycle (1-cycle latency, one write per accepted word).
  - Gaps in src_valid produce gaps in npu_we; no stalls otherwise.
  - Fields latched by header index:
    - 0: num_layers = word[1:0]; value 3 is illegal and triggers an abort, word not forwarded.
    - 1..4: n0..n3 = word[4:0] (neuron count = field + 1).
    - 5: do_act = word[2:0].
  - After word 5 is accepted, go to CALC.
- CALC: one cycle, src_ready=0. Computes the payload count P:
  - Layer chain: in0 = n0+1, then the hidden counts in order (n1+1, and n2+1 if num_layers=2), ending with out = n3+1.
  - P = sum over each layer of out_cnt x (in_cnt + 1), plus (n0+1) input words.
  - All arithmetic is unsigned in CNT_W bits.
- LOAD: src_ready = 1 while remaining > 0; each accepted word is decremented from remaining and forwarded exactly as in HDR. When remaining reaches 0 and the final npu_we cycle is complete, go to WAIT_RDY.
- WAIT_RDY:
  - Bus released, with at least one turnaround cycle between the last npu_we and the first npu_oe.
  - A timeout counter increments every cycle. On npu_ready=1, go to READ.
  - If the counter reaches TIMEOUT_CYCLES first: set err and go to IDLE.
- READ:
  - npu_oe = (!res_valid || res_ready) and results_captured < n3+1 (combinational).
  - On each clk edge with npu_oe=1: res_data <= npu_data, res_valid <= 1, results_captured increments.
  - res_valid clears when res_ready=1 and no new capture occurs that cycle.
  - Once n3+1 words are captured and the last one is accepted, go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Abort (illegal num_layers or timeout): npu_we/npu_oe deasserted the same cycle, src_ready=0, err=1, state goes to IDLE; no done pulse.
- Counters and corner cases:
  - remaining and results_captured never wrap; remaining is held at 0.
  - A start pulse while busy is ignored.
  - npu_we and npu_oe are never high in the same cycle.

Test Plan:
- Zero-hidden job: header {0,1,x,x,0,1}, P=1x3+2=5. Expect 11 npu_we pulses carrying the words in order, then one npu_oe read; res_data equals the value the NPU model drove; done pulses once.
- One-hidden job: n0=3, n1=7, n3=1, P=8x5+2x9+4=62. Expect 68 writes, 2 results, done pulse.
- src_valid toggling 1/0 every cycle during LOAD: expect npu_we toggling identically, all 62 payload words delivered in order, none duplicated.
- res_ready held low for 3 cycles after the first result: expect npu_oe=0 during the stall, exactly 2 captures total, results in order.
- Header word0=3: expect err=1, no npu_we for that word, state back to IDLE, no done; the next start clears err.
- npu_ready never asserted with TIMEOUT_CYCLES=16: expect err after 16 WAIT_RDY cycles. Separately, rst_n pulsed low mid-LOAD: expect all outputs 0 and npu_data=Z immediately, and busy=0.

Source files
------------

// File: rtl/npu_host_ctrl_if.sv
// Valid/ready word stream used for the job source and result sink.
// The master drives data/valid, the slave drives ready.
interface npu_host_ctrl_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/npu_host_ctrl.sv
// Host-side sequencer for one NPU: streams a job onto the shared bus,
// waits for the NPU to finish, then reads results back out.
module npu_host_ctrl #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    npu_host_ctrl_if.slave     src,
    inout  wire  [31:0]        npu_data,
    output logic               npu_we,
    output logic               npu_oe,
    input  logic               npu_ready,
    npu_host_ctrl_if.master    res
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_READ = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       nl_q, nl_d;
    logic [4:0]       n0_q, n0_d;
    logic [4:0]       n1_q, n1_d;
    logic [4:0]       n2_q, n2_d;
    logic [4:0]       n3_q, n3_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [5:0]       cap_q, cap_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic             src_rdy;
    logic             oe;
    logic [5:0]       out_cnt;
    logic [CNT_W-1:0] in0, h1, h2, outw, p_calc;

    // Bus is ours only on write cycles; the NPU owns it otherwise.
    assign npu_data  = we_q ? wdata_q : 32'bz;
    assign npu_we    = we_q;
    assign npu_oe    = oe;
    assign src.ready = src_rdy;
    assign res.data  = rdata_q;
    assign res.valid = rvalid_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign err       = err_q;
    assign out_cnt   = {1'b0, n3_q} + 6'd1;

    // Payload size: weights plus one bias per neuron for every layer,
    // followed by the input vector.
    always_comb begin
        in0  = CNT_W'(n0_q) + ONE;
        h1   = CNT_W'(n1_q) + ONE;
        h2   = CNT_W'(n2_q) + ONE;
        outw = CNT_W'(n3_q) + ONE;
        unique case (nl_q)
            2'd0:    p_calc = outw * (in0 + ONE) + in0;
            2'd1:    p_calc = h1 * (in0 + ONE)
                            + outw * (h1 + ONE) + in0;
            default: p_calc = h1 * (in0 + ONE)
                            + h2 * (h1 + ONE)
                            + outw * (h2 + ONE) + in0;
        endcase
    end

    // Sequencer next-state, bus strobes and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        nl_d     = nl_q;
        n0_d     = n0_q;
        n1_d     = n1_q;
        n2_d     = n2_q;
        n3_d     = n3_q;
        tmo_d    = tmo_q;
        cap_d    = cap_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        src_rdy  = 1'b0;
        oe       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_HDR: begin
                src_rdy = 1'b1;
                if (src.valid) begin
                    if (cnt_q == '0 && src.data[1:0] == 2'd3) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = src.data;
                        cnt_d   = cnt_q + ONE;
                        case (cnt_q[2:0])
                            3'd0:    nl_d = src.data[1:0];
                            3'd1:    n0_d = src.data[4:0];
                            3'd2:    n1_d = src.data[4:0];
                            3'd3:    n2_d = src.data[4:0];
                            3'd4:    n3_d = src.data[4:0];
                            default: ;
                        endcase
                        if (cnt_q == CNT_W'(5)) begin
                            state_d = S_CALC;
                        end
                    end
                end
            end
            S_CALC: begin
                cnt_d   = p_calc;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                src_rdy = (cnt_q != '0);
                if (cnt_q == '0) begin
                    // The last write is on the bus this cycle.
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end else if (src.valid) begin
                    we_d    = 1'b1;
                    wdata_d = src.data;
                    cnt_d   = cnt_q - ONE;
                end
            end
            S_WAIT: begin
                if (npu_ready) begin
                    state_d = S_READ;
                    cap_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_READ: begin
                oe = (!rvalid_q || res.ready) && (cap_q < out_cnt);
                if (oe) begin
                    rdata_d  = npu_data;
                    rvalid_d = 1'b1;
                    cap_d    = cap_q + 6'd1;
                end else if (res.ready) begin
                    rvalid_d = 1'b0;
                end
                if (cap_q == out_cnt && rvalid_q && res.ready) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            nl_q     <= '0;
            n0_q     <= '0;
            n1_q     <= '0;
            n2_q     <= '0;
            n3_q     <= '0;
            tmo_q    <= '0;
            cap_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            nl_q     <= nl_d;
            n0_q     <= n0_d;
            n1_q     <= n1_d;
            n2_q     <= n2_d;
            n3_q     <= n3_d;
            tmo_q    <= tmo_d;
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_npu_host_ctrl.sv
// Directed bench for npu_host_ctrl with a small NPU bus model and
// scoreboards for bus writes and result words.
module tb_npu_host_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, err;
    logic        npu_we, npu_oe, npu_ready;
    wire  [31:0] npu_data;
    logic [31:0] rd_val;

    npu_host_ctrl_if src_if ();
    npu_host_ctrl_if res_if ();

    npu_host_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .src       (src_if),
        .npu_data  (npu_data),
        .npu_we    (npu_we),
        .npu_oe    (npu_oe),
        .npu_ready (npu_ready),
        .res       (res_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int oe_cnt = 0;
    int done_cnt = 0;
    logic [31:0] exp_wr[$];
    logic [31:0] exp_res[$];

    int cur_p, cur_out, wr_base, oe_base, done_base;

    // NPU read model: each read returns a value tied to its global index.
    assign rd_val   = 32'hC0DE0000 + 32'(oe_cnt) * 32'h00010003;
    assign npu_data = npu_oe ? rd_val : 32'bz;

    always @(posedge clk) begin
        if (npu_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("we_oe_excl", 32'(npu_we & npu_oe), 32'd0);
            if (npu_we) begin
                wr_cnt++;
                chk("wr_avail", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0)
                    chk("wr_data", npu_data, exp_wr.pop_front());
            end
            if (res_if.valid && res_if.ready) begin
                chk("res_avail", 32'(exp_res.size() != 0), 32'd1);
                if (exp_res.size() != 0)
                    chk("res_data", res_if.data, exp_res.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    function automatic int calc_p(int nl, int n0, int n1, int n2, int n3);
        int i0 = n0 + 1;
        int o  = n3 + 1;
        int a  = n1 + 1;
        int b  = n2 + 1;
        int p;
        case (nl)
            0:       p = o * (i0 + 1);
            1:       p = a * (i0 + 1) + o * (a + 1);
            default: p = a * (i0 + 1) + b * (a + 1) + o * (b + 1);
        endcase
        return p + i0;
    endfunction

    task automatic send(input logic [31:0] w, input bit fwd,
                        input bit gap);
        int n = 0;
        if (fwd) exp_wr.push_back(w);
        src_if.data  = w;
        src_if.valid = 1'b1;
        @(negedge clk);
        while (!src_if.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("src_accept", 32'(src_if.ready), 32'd1);
        @(posedge clk); #1;
        src_if.valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Starts a job and streams header plus payload (or stop_at words).
    task automatic run_job(input int nl, input int n0, input int n1,
                           input int n2, input int n3, input bit gap,
                           input int stop_at);
        logic [31:0] r;
        int lim;
        cur_p     = calc_p(nl, n0, n1, n2, n3);
        cur_out   = n3 + 1;
        wr_base   = wr_cnt;
        oe_base   = oe_cnt;
        done_base = done_cnt;
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err_clr", 32'(err), 32'd0);
        r = $urandom(); send({r[31:2], 2'(nl)}, 1'b1, 1'b0);
        r = $urandom(); send({r[31:5], 5'(n0)}, 1'b1, 1'b0);
        r = $urandom(); send({r[31:5], 5'(n1)}, 1'b1, 1'b0);
        r = $urandom(); send({r[31:5], 5'(n2)}, 1'b1, 1'b0);
        r = $urandom(); send({r[31:5], 5'(n3)}, 1'b1, 1'b0);
        r = $urandom(); send(r, 1'b1, 1'b0);
        lim = (stop_at >= 0) ? stop_at : cur_p;
        for (int i = 0; i < lim; i++) begin
            send($urandom(), 1'b1, gap);
        end
    endtask

    task automatic finish_ok(input bit stall);
        int cyc = 0;
        bit stalled = 1'b0;
        for (int k = 0; k < cur_out; k++)
            exp_res.push_back(32'hC0DE0000 + 32'(oe_base + k) * 32'h00010003);
        npu_ready    = 1'b1;
        res_if.ready = 1'b1;
        while (done_cnt == done_base && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stall && !stalled && res_if.valid && res_if.ready) begin
                stalled = 1'b1;
                @(posedge clk); #1;
                res_if.ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_oe", 32'(npu_oe), 32'd0);
                end
                @(posedge clk); #1;
                res_if.ready = 1'b1;
            end
        end
        chk("done_seen", 32'(cyc < 400), 32'd1);
        @(posedge clk); #1;
        npu_ready = 1'b0;
        chk("wr_count", 32'(wr_cnt - wr_base), 32'(6 + cur_p));
        chk("rd_count", 32'(oe_cnt - oe_base), 32'(cur_out));
        chk("done_count", 32'(done_cnt - done_base), 32'd1);
        chk("wr_left", 32'(exp_wr.size()), 32'd0);
        chk("res_left", 32'(exp_res.size()), 32'd0);
        chk("job_err", 32'(err), 32'd0);
        chk("job_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_src_ready", 32'(src_if.ready), 32'd0);
        chk("rst_we", 32'(npu_we), 32'd0);
        chk("rst_oe", 32'(npu_oe), 32'd0);
        chk("rst_res_valid", 32'(res_if.valid), 32'd0);
        chk("rst_res_data", res_if.data, 32'd0);
        chk("rst_bus_z", npu_data, 32'bz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] r;
        rst_n        = 1'b0;
        start        = 1'b0;
        npu_ready    = 1'b0;
        src_if.data  = '0;
        src_if.valid = 1'b0;
        res_if.ready = 1'b1;
        #12;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Illegal layer count: aborted, nothing written, no done.
        wr_base   = wr_cnt;
        done_base = done_cnt;
        pulse_start();
        r = $urandom();
        send({r[31:2], 2'd3}, 1'b0, 1'b0);
        @(negedge clk);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("ill_no_wr", 32'(wr_cnt - wr_base), 32'd0);
        chk("ill_no_done", 32'(done_cnt - done_base), 32'd0);

        // Zero hidden layers: P = 5, 11 writes, 1 result.
        run_job(0, 1, 9, 4, 0, 1'b0, -1);
        finish_ok(1'b0);

        // One hidden layer: P = 62, 68 writes, 2 results.
        run_job(1, 3, 7, 0, 1, 1'b0, -1);
        finish_ok(1'b0);

        // Same job with a bubble after every payload word.
        run_job(1, 3, 7, 0, 1, 1'b1, -1);
        finish_ok(1'b0);

        // Three outputs with the consumer stalling after the first.
        run_job(1, 3, 7, 0, 2, 1'b0, -1);
        finish_ok(1'b1);

        // Two hidden layers.
        run_job(2, 2, 4, 3, 2, 1'b0, -1);
        finish_ok(1'b0);

        // NPU never ready: one drain cycle in LOAD, then TMO wait cycles.
        run_job(0, 1, 0, 0, 0, 1'b0, -1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO + 1));
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_no_done", 32'(done_cnt - done_base), 32'd0);
        chk("tmo_wr_count", 32'(wr_cnt - wr_base), 32'(6 + cur_p));

        // Next start clears the sticky error.
        run_job(0, 1, 0, 0, 0, 1'b0, -1);
        finish_ok(1'b0);

        // Reset in the middle of the payload.
        run_job(1, 3, 7, 0, 1, 1'b0, 20);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_wr.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(busy), 32'd0);

        run_job(0, 1, 0, 0, 0, 1'b0, -1);
        finish_ok(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
